// File: rtl/mac_dot_sequencer_if.sv
// Operand stream, accumulator control and result port of mac_dot_sequencer.
// The sequencer connects through the slave modport; the upstream/downstream side uses master.
interface mac_dot_sequencer_if #(
  parameter int unsigned LEN_W = 5
);
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [8:0]       in_a;
  logic signed [8:0]       in_b;
  logic signed [8:0]       mac_dataa;
  logic signed [8:0]       mac_datab;
  logic                    mac_clken;
  logic                    mac_sload;
  logic signed [18:0]      mac_result;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [18:0]      res_data;
  logic                    res_ovf;
  logic                    busy;

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_result, res_ready,
    output in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data, res_ovf, busy
  );

  modport master (
    output start, len, in_valid, in_a, in_b, mac_result, res_ready,
    input  in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences one dot product per start command through an external signed 9x9 accumulator.
// Optional overflow shadow accumulator enabled by defining MAC_SEQ_OVF_EN.
module mac_dot_sequencer #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned LEN_W = 5
) (
  input logic                 clk,
  input logic                 aclr,
  mac_dot_sequencer_if.slave  bus
);

  localparam int unsigned RES_W = 19;
  localparam int unsigned SH_W  = 24;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  localparam logic [LEN_W-1:0] N_MAX_L = LEN_W'(N_MAX);

  logic [1:0]              state, state_nxt;
  logic [LEN_W-1:0]        cnt, cnt_nxt;
  logic [LEN_W-1:0]        target, target_nxt;
  logic                    res_valid_q, res_valid_nxt;
  logic signed [RES_W-1:0] res_data_q, res_data_nxt;
  logic                    res_ovf_q, res_ovf_nxt;

  logic beat_c;
  logic last_c;
  logic capture_c;
  logic ovf_c;

  assign beat_c    = bus.in_valid && (state == S_RUN);
  assign last_c    = beat_c && (cnt == LEN_W'(target - LEN_W'(1)));
  assign capture_c = (state == S_CAP) && (!res_valid_q || bus.res_ready);

`ifdef MAC_SEQ_OVF_EN
  // Wide shadow sum; restarts on the first beat, matching the accumulator's sload clear.
  logic signed [SH_W-1:0] shadow;
  logic signed [17:0]     prod_c;
  logic signed [SH_W-1:0] shadow_sum_c;

  assign prod_c       = bus.in_a * bus.in_b;
  assign shadow_sum_c = ((cnt == '0) ? SH_W'(0) : shadow) + SH_W'(prod_c);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      shadow <= '0;
    end else if (beat_c) begin
      shadow <= shadow_sum_c;
    end
  end

  // In range of a 19-bit signed value iff the top bits are all copies of bit 18.
  assign ovf_c = (shadow[SH_W-1:RES_W-1] != {(SH_W-RES_W+1){shadow[RES_W-1]}});
`else
  assign ovf_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state       <= S_IDLE;
      cnt         <= '0;
      target      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      target      <= target_nxt;
      res_valid_q <= res_valid_nxt;
      res_data_q  <= res_data_nxt;
      res_ovf_q   <= res_ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    target_nxt    = target;
    res_valid_nxt = res_valid_q;
    res_data_nxt  = res_data_q;
    res_ovf_nxt   = res_ovf_q;

    // A capture in the same cycle overrides the consume below.
    if (res_valid_q && bus.res_ready) begin
      res_valid_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          target_nxt = (bus.len > N_MAX_L) ? N_MAX_L : bus.len;
          cnt_nxt    = '0;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_c) begin
          cnt_nxt = cnt + LEN_W'(1);
          if (last_c) begin
            state_nxt = S_CAP;
          end
        end
      end
      S_CAP: begin
        if (capture_c) begin
          res_data_nxt  = bus.mac_result;
          res_ovf_nxt   = ovf_c;
          res_valid_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state == S_RUN);
  assign bus.mac_dataa = bus.in_a;
  assign bus.mac_datab = bus.in_b;
  assign bus.mac_clken = beat_c;
  assign bus.mac_sload = last_c;
  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: directed vector table, hand sequences, random scoreboard.
// Includes a behavioural stand-in for the downstream accumulator (registered sload).
module tb_mac_dot_sequencer;

  localparam int unsigned LEN_W = 5;
  localparam int unsigned N_MAX = 16;
`ifdef MAC_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic aclr;

  mac_dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

  mac_dot_sequencer #(.N_MAX(N_MAX), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream accumulator: sload is registered on enabled beats, so it clears the next beat.
  logic signed [18:0] acc;
  logic               sl_q;
  logic signed [17:0] prod;
  assign prod = bus.mac_dataa * bus.mac_datab;
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc  <= '0;
      sl_q <= 1'b0;
    end else if (bus.mac_clken) begin
      acc  <= (sl_q ? 19'sd0 : acc) + 19'(prod);
      sl_q <= bus.mac_sload;
    end
  end
  assign bus.mac_result = acc;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  typedef struct {
    int len;
    int a[4];
    int b[4];
    int gap;
    int exp_data;
    bit exp_ovf;
  } vec_t;

  vec_t tv[5];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rr_rand  = 1'b0;
  int   va[16];
  int   vb[16];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", name, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference: dot product of the first min(len, N_MAX) pairs, wrapped to 19 bits.
  function automatic exp_t model(input int l, input int a[16], input int b[16]);
    int n;
    int s;
    logic signed [18:0] w;
    exp_t e;
    n = (l > int'(N_MAX)) ? int'(N_MAX) : l;
    s = 0;
    for (int i = 0; i < n; i++) s += a[i] * b[i];
    w = 19'(s);
    e.data = int'(w);
    e.ovf  = OVF_EN && ((s < -262144) || (s > 262143));
    return e;
  endfunction

  // Scoreboard: every handshake on the result port must match the oldest expected result.
  task automatic mon();
    exp_t e;
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0d required=no_result", int'(bus.res_data));
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", int'(bus.res_data), e.data);
        chk("sb_ovf", int'(bus.res_ovf), int'(e.ovf));
      end
    end
  endtask

  // Phase discipline: neg() samples at the falling edge, tick() drives just after the rising edge.
  task automatic neg();
    @(negedge clk);
    mon();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_vec(input int l);
    int t;
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    neg();
    t = 0;
    while (bus.busy && t < 200) begin
      tick();
      neg();
      t++;
    end
    if (bus.busy) abort("start_accept");
    tick();
    bus.start = 1'b0;
    bus.len   = LEN_W'($urandom);
  endtask

  task automatic send_pair(input int a, input int b, input int gap, input bit last);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_a     = 9'($urandom);
      bus.in_b     = 9'($urandom);
      neg();
      chk("gap_clken", int'(bus.mac_clken), 0);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 9'(a);
    bus.in_b     = 9'(b);
    neg();
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      neg();
      t++;
    end
    if (!bus.in_ready) abort("in_ready");
    chk("beat_clken", int'(bus.mac_clken), 1);
    chk("beat_sload", int'(bus.mac_sload), int'(last));
    chk("beat_dataa", int'(bus.mac_dataa), a);
    chk("beat_datab", int'(bus.mac_datab), b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input int l, input int a[16], input int b[16], input int gap1, input bit rgap);
    int n;
    int g;
    n = (l > int'(N_MAX)) ? int'(N_MAX) : l;
    exp_q.push_back(model(l, a, b));
    start_vec(l);
    for (int i = 0; i < n; i++) begin
      if (rgap) g = int'($urandom_range(0, 2));
      else      g = (i == 1) ? gap1 : 0;
      send_pair(a[i], b[i], g, (i == n - 1));
    end
  endtask

  // Leaves the caller at the falling edge where res_valid is first seen high.
  task automatic wait_result();
    for (int t = 0; t < 100; t++) begin
      neg();
      if (bus.res_valid) return;
      tick();
    end
    abort("wait_result");
  endtask

  task automatic set_vec(input int a0, input int b0, input int a1, input int b1);
    for (int i = 0; i < 16; i++) begin
      va[i] = 0;
      vb[i] = 0;
    end
    va[0] = a0; vb[0] = b0;
    va[1] = a1; vb[1] = b1;
  endtask

  initial begin
    tv[0] = '{3, '{2, -4, 7, 0},          '{3, 5, 7, 0},            0, 35,      1'b0};
    tv[1] = '{3, '{2, -4, 7, 0},          '{3, 5, 7, 0},            2, 35,      1'b0};
    tv[2] = '{2, '{10, 1, 0, 0},          '{10, 1, 0, 0},           0, 101,     1'b0};
    tv[3] = '{1, '{-3, 0, 0, 0},          '{4, 0, 0, 0},            0, -12,     1'b0};
    tv[4] = '{4, '{-256, -256, -256, -256}, '{-256, -256, -256, -256}, 0, -262144, 1'b1};

    aclr          = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b1;

    // Reset state
    neg();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_clken", int'(bus.mac_clken), 0);
    chk("rst_sload", int'(bus.mac_sload), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_res_ovf", int'(bus.res_ovf), 0);
    tick();
    aclr         = 1'b0;
    bus.in_valid = 1'b0;

    // Directed table, each with a free result port: result two cycles after the last beat
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) begin
        va[i] = (i < 4) ? tv[k].a[i] : 0;
        vb[i] = (i < 4) ? tv[k].b[i] : 0;
      end
      run_vec(tv[k].len, va, vb, tv[k].gap, 1'b0);
      neg();
      chk("lat_cap_busy", int'(bus.busy), 1);
      chk("lat_cap_valid", int'(bus.res_valid), 0);
      tick();
      neg();
      chk("lat_valid", int'(bus.res_valid), 1);
      chk("tbl_data", int'(bus.res_data), tv[k].exp_data);
      chk("tbl_ovf", int'(bus.res_ovf), int'(OVF_EN && tv[k].exp_ovf));
      chk("tbl_idle", int'(bus.busy), 0);
      tick();
    end

    // Backpressure: second result waits in CAP, then loads on the consuming cycle
    bus.res_ready = 1'b0;
    set_vec(10, 10, 1, 1);
    run_vec(2, va, vb, 0, 1'b0);
    wait_result();
    chk("bp_first", int'(bus.res_data), 101);
    tick();
    set_vec(-3, 4, 0, 0);
    run_vec(1, va, vb, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      neg();
      chk("bp_busy", int'(bus.busy), 1);
      chk("bp_hold_valid", int'(bus.res_valid), 1);
      chk("bp_hold_data", int'(bus.res_data), 101);
      tick();
    end
    bus.res_ready = 1'b1;
    neg();
    tick();
    neg();
    chk("bp_valid_kept", int'(bus.res_valid), 1);
    chk("bp_second", int'(bus.res_data), -12);
    chk("bp_idle", int'(bus.busy), 0);
    tick();
    neg();
    chk("bp_drained", int'(bus.res_valid), 0);
    tick();

    // aclr mid-vector, zero-length start ignored, then a fresh vector
    start_vec(4);
    send_pair(3, 3, 0, 1'b0);
    send_pair(3, 3, 0, 1'b0);
    aclr         = 1'b1;
    bus.in_valid = 1'b1;
    neg();
    chk("aclr_busy", int'(bus.busy), 0);
    chk("aclr_in_ready", int'(bus.in_ready), 0);
    chk("aclr_clken", int'(bus.mac_clken), 0);
    chk("aclr_res_valid", int'(bus.res_valid), 0);
    tick();
    aclr         = 1'b0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    bus.len      = '0;
    neg();
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    neg();
    chk("len0_busy", int'(bus.busy), 0);
    chk("len0_in_ready", int'(bus.in_ready), 0);
    chk("len0_clken", int'(bus.mac_clken), 0);
    chk("len0_sload", int'(bus.mac_sload), 0);
    chk("len0_res_valid", int'(bus.res_valid), 0);
    chk("len0_res_data", int'(bus.res_data), 0);
    chk("len0_res_ovf", int'(bus.res_ovf), 0);
    tick();
    bus.in_valid = 1'b0;
    set_vec(5, 5, 0, 0);
    run_vec(1, va, vb, 0, 1'b0);
    wait_result();
    chk("post_aclr_data", int'(bus.res_data), 25);
    tick();

    // Random vectors (including lengths above N_MAX), random gaps and result backpressure
    rr_rand = 1'b1;
    for (int v = 0; v < 25; v++) begin
      for (int i = 0; i < 16; i++) begin
        va[i] = int'($urandom_range(0, 511)) - 256;
        vb[i] = int'($urandom_range(0, 511)) - 256;
      end
      run_vec(int'($urandom_range(1, 31)), va, vb, 0, 1'b1);
    end
    rr_rand       = 1'b0;
    bus.res_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      neg();
      tick();
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
